// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared constants and state encoding for the truth-table scanner
package tt_pkg;

  localparam int NUM_MINTERMS = 16;
  localparam int IDX_W        = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DRIVE  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_SAMPLE = 3'd3;
  localparam state_t ST_CHECK  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

endpackage

// File: rtl/truth_table_scanner_popcount16.sv
// rtl/truth_table_scanner_popcount16.sv - combinational 16-bit population count
module popcount16
  import tt_pkg::*;
(
  input  logic [15:0] bits,
  output logic [4:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_MINTERMS; i++) begin
      count = count + {4'd0, bits[i]};
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - sweeps 16 minterms into a function block and captures its truth table
module truth_table_scanner
  import tt_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        match,
  output logic [4:0]  ones
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        table_q, table_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               match_q, match_d;
  logic [4:0]         ones_q, ones_d;
  logic [4:0]         pop;

  popcount16 u_popcount16 (
    .bits  (table_q),
    .count (pop)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    busy_d  = busy_q;
    done_d  = done_q;
    match_d = match_q;
    ones_d  = ones_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          table_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          match_d = 1'b0;
          ones_d  = '0;
        end
      end
      ST_DRIVE: begin
        cnt_d   = CNT_W'(SETTLE - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        table_d[idx_q] = f;
        // the loop exits through CHECK, so idx never wraps
        if (idx_q != IDX_W'(NUM_MINTERMS - 1)) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        match_d = (table_q == expected);
        ones_d  = pop;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      ones_q  <= ones_d;
    end
  end

  assign {a, b, c, d} = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign match        = match_q;
  assign ones         = ones_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - self-checking bench for truth_table_scanner
module tb_truth_table_scanner;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic [15:0] expected = 16'h0000;
  logic        f;
  logic        a, b, c, d, busy, done, match;
  logic [15:0] table_out;
  logic [4:0]  ones;
  logic        a1, b1, c1, d1, busy1, done1, match1;
  logic [15:0] table1;
  logic [4:0]  ones1;

  int          checks = 0;
  int          errors = 0;
  int          mode = 0;
  logic [15:0] rand_tt = 16'h0000;
  int          cyc;
  int          seq_err;

  truth_table_scanner #(.SETTLE(2), .CNT_W(4)) u_dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .expected(expected), .f(f),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .table_out(table_out), .match(match), .ones(ones)
  );

  truth_table_scanner #(.SETTLE(1), .CNT_W(4)) u_dut1 (
    .Clock(Clock), .Resetn(Resetn), .start(start1), .expected(16'hFFFF), .f(1'b1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .table_out(table1), .match(match1), .ones(ones1)
  );

  always #5 Clock = ~Clock;

  // function blocks under test
  always_comb begin
    f = 1'b0;
    case (mode)
      0:       f = a ^ b ^ c ^ d;
      1:       f = ~a & (b ? d : (c | ~d));
      default: f = rand_tt[{a, b, c, d}];
    endcase
  end

  function automatic logic [15:0] model_tt(input int m);
    logic [15:0] r;
    logic [3:0]  mt;
    r = 16'h0000;
    case (m)
      0: for (int i = 0; i < 16; i++) begin
           mt = 4'(i);
           r[i] = ^mt;
         end
      1: r = 16'h00AD;
      default: r = rand_tt;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input int settle, input int glitch_at, output int n, output int serr);
    int e;
    @(negedge Clock);
    start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    n = 0;
    serr = 0;
    if ({a, b, c, d} !== 4'd0) serr++;
    do begin
      @(posedge Clock);
      #1;
      n++;
      start = (glitch_at != 0 && n == glitch_at);
      if (!done) begin
        e = n / (settle + 2);
        if (e > 15) e = 15;
        if ({a, b, c, d} !== 4'(e)) serr++;
        if (busy !== 1'b1) serr++;
      end
    end while (!done && n < 300);
    start = 1'b0;
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    do begin
      @(posedge Clock);
      #1;
      n++;
    end while (!done1 && n < 300);
  endtask

  initial begin
    logic [15:0] m;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_match", 32'(match), 32'd0);
    chk("reset_table", 32'(table_out), 32'd0);
    chk("reset_ones", 32'(ones), 32'd0);
    chk("reset_abcd", 32'({a, b, c, d}), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    // reset asserted partway through a sweep
    mode = 0;
    expected = 16'h6996;
    @(negedge Clock);
    start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    repeat (20) @(posedge Clock);
    #1;
    Resetn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_table", 32'(table_out), 32'd0);
    chk("midrst_abcd", 32'({a, b, c, d}), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (80) @(posedge Clock);
    #1;
    chk("midrst_nodone", 32'(done), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    // parity function, stimulus ordering and latency
    run_sweep(2, 0, cyc, seq_err);
    m = model_tt(0);
    chk("xor_latency", 32'(cyc), 32'd65);
    chk("xor_table", 32'(table_out), 32'(m));
    chk("xor_match", 32'(match), 32'd1);
    chk("xor_ones", 32'(ones), 32'($countones(m)));
    chk("xor_busy", 32'(busy), 32'd0);
    chk("xor_order", 32'(seq_err), 32'd0);

    // reference lab function, matching and mismatching golden values
    mode = 1;
    expected = 16'h00AD;
    run_sweep(2, 0, cyc, seq_err);
    m = model_tt(1);
    chk("lab_table", 32'(table_out), 32'(m));
    chk("lab_match", 32'(match), 32'd1);
    chk("lab_ones", 32'(ones), 32'd5);
    expected = 16'h00AC;
    run_sweep(2, 0, cyc, seq_err);
    chk("lab_mismatch", 32'(match), 32'd0);
    chk("lab_mismatch_ones", 32'(ones), 32'd5);

    // start while busy is ignored
    mode = 0;
    expected = 16'h6996;
    run_sweep(2, 30, cyc, seq_err);
    chk("busy_start_latency", 32'(cyc), 32'd65);
    chk("busy_start_table", 32'(table_out), 32'h6996);
    chk("busy_start_match", 32'(match), 32'd1);
    chk("busy_start_order", 32'(seq_err), 32'd0);

    // random truth tables
    mode = 2;
    for (int k = 0; k < 4; k++) begin
      rand_tt = 16'($urandom);
      expected = ($urandom_range(0, 1) == 1) ? rand_tt : (rand_tt ^ (16'h0001 << $urandom_range(0, 15)));
      run_sweep(2, 0, cyc, seq_err);
      m = model_tt(2);
      chk("rand_latency", 32'(cyc), 32'd65);
      chk("rand_table", 32'(table_out), 32'(m));
      chk("rand_match", 32'(match), 32'(expected == m));
      chk("rand_ones", 32'(ones), 32'($countones(m)));
    end

    // start held high: back-to-back sweeps with a single DONE cycle
    @(negedge Clock);
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge Clock);
      #1;
      cyc++;
    end while (!done && cyc < 300);
    chk("held_done", 32'(done), 32'd1);
    @(posedge Clock);
    #1;
    chk("held_restart_done", 32'(done), 32'd0);
    chk("held_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    cyc = 0;
    do begin
      @(posedge Clock);
      #1;
      cyc++;
    end while (!done && cyc < 300);
    chk("held_second_done", 32'(done), 32'd1);

    // SETTLE=1 instance with f tied high, then restart from DONE
    @(negedge Clock);
    start1 = 1'b1;
    @(posedge Clock);
    #1;
    start1 = 1'b0;
    wait_done1(cyc);
    chk("s1_latency", 32'(cyc), 32'd49);
    chk("s1_table", 32'(table1), 32'hFFFF);
    chk("s1_ones", 32'(ones1), 32'd16);
    chk("s1_match", 32'(match1), 32'd1);
    @(negedge Clock);
    start1 = 1'b1;
    @(posedge Clock);
    #1;
    start1 = 1'b0;
    chk("s1_restart_table", 32'(table1), 32'd0);
    chk("s1_restart_done", 32'(done1), 32'd0);
    chk("s1_restart_ones", 32'(ones1), 32'd0);
    chk("s1_restart_busy", 32'(busy1), 32'd1);
    wait_done1(cyc);
    chk("s1_latency2", 32'(cyc), 32'd49);
    chk("s1_table2", 32'(table1), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus/capture stage sitting directly upstream of, and wrapped around, a 4-input combinational function block (inputs a,b,c,d; output f).
- On a start pulse it sweeps all 16 minterms onto a,b,c,d, waits a programmable settle time, and samples f into a 16-bit truth-table register.
- It then compares the table against an expected value and reports done/match, allowing lab functions to be self-checked on hardware or in simulation.

Parameters:
- SETTLE, 2, cycles between driving a minterm and sampling f (legal range 1..15).
- CNT_W, 4, width of the settle counter.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; honoured only in IDLE or DONE.
- expected  input  16  golden truth table; bit i = f at minterm i.
- f  input  1  output of the function block under test.
- a  output  1  minterm bit 3 (MSB).
- b  output  1  minterm bit 2.
- c  output  1  minterm bit 1.
- d  output  1  minterm bit 0 (LSB).
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start.
- table  output  16  captured truth table.
- match  output  1  table == expected; valid only while done=1.
- ones  output  5  population count of table (0..16); valid only while done=1.

Behaviour:
- Reset (Resetn=0, asynchronous): state=IDLE; a=b=c=d=0; busy=0; done=0; match=0; table=16'h0000; ones=0. Deassertion is synchronous to Clock by assumption of the top level.
- States:
  - IDLE: wait for start.
  - DRIVE: present the minterm; the settle counter loads SETTLE-1.
  - SETTLE: count down to 0.
  - SAMPLE: table[idx] <= f.
  - CHECK: compute match and ones.
  - DONE: hold results.
- Transitions:
  - IDLE/DONE --start--> DRIVE. On this edge: idx=0, table cleared, done=0, match=0, ones=0, busy=1.
  - DRIVE -> SETTLE.
  - SETTLE stays while count != 0, then goes to SAMPLE.
  - SAMPLE -> DRIVE with idx+1 if idx != 15; otherwise -> CHECK.
  - CHECK -> DONE: busy=0, done=1, match and ones registered.
- Outputs:
  - {a,b,c,d} = idx, registered, and change only on entry to DRIVE.
  - f is therefore stable for SETTLE+1 edges before it is sampled.
- Latency: per minterm = SETTLE+2 cycles. Full sweep = 16*(SETTLE+2)+1 cycles from the start edge to done=1; with SETTLE=2 this is 65 cycles.
- Arithmetic and widths:
  - idx is 4-bit; the 15 -> 0 wrap is never used because CHECK exits the loop.
  - ones is the sum of the 16 table bits, zero-extended to 5 bits.
- Boundary conditions:
  - start while busy: ignored; no restart, no effect on the table.
  - start in DONE: begins a new sweep; results clear on that edge.
  - start held high continuously: back-to-back sweeps, each with a single DONE cycle.
  - Resetn asserted mid-sweep: immediate return to the reset values; a partial table is discarded.
  - SETTLE=1: the SETTLE state is occupied for exactly one cycle (count=0 on entry).
  - f may change only when {a,b,c,d} changes. A value of f that is X at sample time propagates into table in simulation; it is not masked.

Decomposition:
- Shared package tt_pkg holds:
  - the state enumeration typedef (IDLE, DRIVE, SETTLE, SAMPLE, CHECK, DONE);
  - the constant NUM_MINTERMS=16;
  - the constant IDX_W=4.
- One natural sub-module: popcount16, a combinational 16 -> 5 bit population count used in CHECK.
- The function block under test is instantiated by the bench or top level, not inside this block.

Test Plan:
1. Reset mid-sweep: assert Resetn=0 at cycle 20 -> all outputs at reset values in the same cycle; no done afterwards without a new start.
2. f = a^b^c^d, expected=16'h6996, start pulse -> after 65 cycles table=16'h6996, match=1, ones=8, busy=0, done=1.
3. Reference lab function f = ~a & mux(b,c,d) (truth 16'h00AD), expected=16'h00AD -> table=16'h00AD, match=1, ones=5. Repeat with expected=16'h00AC -> match=0.
4. Stimulus ordering: monitor {a,b,c,d} -> it takes values 0,1,...,15 in order, each held 4 cycles (SETTLE=2), and each value changes exactly on DRIVE entry.
5. Second start pulse issued at cycle 30 while busy -> ignored; done is still asserted at cycle 65 with an unchanged result.
6. SETTLE=1 build with f tied to 1 -> done after 49 cycles, table=16'hFFFF, ones=16. Then start again from DONE -> table clears to 0 on that edge and the sweep repeats.
